profile_ci: RTL and testbench

//  Profiling custom-instruction (CI) unit on the CPU custom-instruction port.
//  - Holds four 32-bit event counters; software enables, disables and clears them via valueB.
//  - Software reads one counter, selected by valueA, in the same cycle.
//  - Used to measure cycles, stall cycles and bus-idle cycles of code regions.

---
 rtl/profile_ci_pkg.sv | 19 +
 rtl/profile_ci_counter.sv | 50 +++++
 rtl/profile_ci.sv | 55 +++++
 tb/tb_profile_ci.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/profile_ci_pkg.sv
// Shared constants and control-word layout for the profiling CI unit.
package profile_ci_pkg;

  localparam int unsigned NUM_COUNTERS = 4;
  localparam int unsigned CNT_W        = 32;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned EN_LSB       = 0;
  localparam int unsigned DIS_LSB      = 4;
  localparam int unsigned CLR_LSB      = 8;
  localparam int unsigned CTRL_W       = 12;

  // Control word carried in valueB[11:0]; MSB-first so clr sits at [11:8].
  typedef struct packed {
    logic [NUM_COUNTERS-1:0] clr;
    logic [NUM_COUNTERS-1:0] dis;
    logic [NUM_COUNTERS-1:0] en;
  } ci_ctrl_t;

endpackage

// File: rtl/profile_ci_counter.sv
// One profiling event counter with its own enable flag.
// Ports: clock, reset (sync, active-high), enable/dis (set/clear enable flag,
// dis wins), clear (zero the count, en untouched), evt (event this cycle),
// count (registered counter value).
// Build option: PROFILE_CI_SATURATE_EN makes the counter saturate instead of wrap.
module profile_counter
  import profile_ci_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             dis,
  input  logic             clear,
  input  logic             evt,
  output logic [CNT_W-1:0] count
);

  logic             en;
  logic [CNT_W-1:0] count_inc;

  // Next value on an event: wrap or saturate depending on build.
`ifdef PROFILE_CI_SATURATE_EN
  assign count_inc = (count == {CNT_W{1'b1}}) ? count : count + CNT_W'(1);
`else
  assign count_inc = count + CNT_W'(1);
`endif

  // Enable flag: disable has priority over enable, otherwise hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      en <= 1'b0;
    end else if (dis) begin
      en <= 1'b0;
    end else if (enable) begin
      en <= 1'b1;
    end
  end

  // Count: clear overrides any increment in the same cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && evt) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/profile_ci.sv
// Profiling custom-instruction unit: four event counters controlled and read
// through the CPU custom-instruction port.
// Ports: clock, reset (sync, active-high), start (CI strobe), stall, busIdle
// (event sources), valueA ([1:0] read select), valueB (en/dis/clr fields),
// ciN (CI number), done (combinational completion), result (combinational
// read data, pre-edge counter value, 0 when not selected).
// Build option: PROFILE_CI_SATURATE_EN (counters saturate instead of wrap).
module profile_ci
  import profile_ci_pkg::*;
#(
  parameter logic [7:0] customId = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        busIdle,
  input  logic [31:0] valueA,
  input  logic [31:0] valueB,
  input  logic [7:0]  ciN,
  output logic        done,
  output logic [31:0] result
);

  logic                    sel;
  ci_ctrl_t                ctrl;
  logic [NUM_COUNTERS-1:0] evt;
  logic [CNT_W-1:0]        cnt [NUM_COUNTERS];
  logic                    unused_bits;

  assign sel  = start && (ciN == customId);
  assign ctrl = ci_ctrl_t'(valueB[CTRL_W-1:0]);

  // Upper operand bits carry no meaning for this unit.
  assign unused_bits = ^{valueA[31:SEL_W], valueB[31:CTRL_W]};

  // Event map: cycles, stall cycles, bus-idle cycles, stalls not explained by idle bus.
  assign evt = {stall & ~busIdle, busIdle, stall, 1'b1};

  for (genvar i = 0; i < NUM_COUNTERS; i++) begin : g_cnt
    profile_counter u_cnt (
      .clock  (clock),
      .reset  (reset),
      .enable (sel & ctrl.en[i]),
      .dis    (sel & ctrl.dis[i]),
      .clear  (sel & ctrl.clr[i]),
      .evt    (evt[i]),
      .count  (cnt[i])
    );
  end

  assign done   = sel;
  assign result = sel ? cnt[valueA[SEL_W-1:0]] : 32'd0;

endmodule

// File: tb/tb_profile_ci.sv
// Self-checking bench for profile_ci with a cycle-level reference model.
module tb_profile_ci;

  localparam logic [7:0] ID = 8'h00;

  logic        clk = 1'b0;
  logic        reset, start, stall, busIdle;
  logic [31:0] valueA, valueB;
  logic [7:0]  ciN;
  logic        done;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_cnt [4];
  logic        m_en  [4];

  profile_ci #(.customId(ID)) dut (
    .clock   (clk),
    .reset   (reset),
    .start   (start),
    .stall   (stall),
    .busIdle (busIdle),
    .valueA  (valueA),
    .valueB  (valueB),
    .ciN     (ciN),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  // Drive one cycle, check the combinational outputs, then advance the model
  // to the state the upcoming rising edge produces.
  task automatic do_cycle(input string tag, input logic s, input logic [7:0] ci,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic st, input logic bi, input logic r);
    logic        sel;
    logic [31:0] exp_res;
    logic        ev;
    @(negedge clk);
    start = s; ciN = ci; valueA = a; valueB = b; stall = st; busIdle = bi; reset = r;
    #1;
    sel     = s && (ci == ID);
    exp_res = sel ? m_cnt[a[1:0]] : 32'd0;
    checks++;
    assert (done === sel) else begin
      errors++;
      $error("FAIL %s done: observed %0b expected %0b", tag, done, sel);
    end
    checks++;
    assert (result === exp_res) else begin
      errors++;
      $error("FAIL %s result: observed %h expected %h", tag, result, exp_res);
    end
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: ev = 1'b1;
        1: ev = st;
        2: ev = bi;
        default: ev = st & ~bi;
      endcase
      if (r) begin
        m_cnt[i] = 32'd0;
        m_en[i]  = 1'b0;
      end else begin
        if (sel && b[8+i]) m_cnt[i] = 32'd0;
        else if (m_en[i] && ev) begin
`ifdef PROFILE_CI_SATURATE_EN
          if (m_cnt[i] != 32'hFFFF_FFFF) m_cnt[i] = m_cnt[i] + 32'd1;
`else
          m_cnt[i] = m_cnt[i] + 32'd1;
`endif
        end
        if (sel && b[4+i])      m_en[i] = 1'b0;
        else if (sel && b[i])   m_en[i] = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n, input logic st, input logic bi);
    for (int k = 0; k < n; k++) do_cycle("idle", 1'b0, ID, 32'd0, 32'd0, st, bi, 1'b0);
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 4; i++)
      do_cycle(tag, 1'b1, ID, 32'(i), 32'd0, 1'($urandom), 1'($urandom), 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_cnt[i] = 32'd0;
      m_en[i]  = 1'b0;
    end
    start = 0; ciN = 0; valueA = 0; valueB = 0; stall = 0; busIdle = 0; reset = 1;

    // 1: reset then idle
    do_cycle("reset", 1'b0, ID, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    do_cycle("reset", 1'b1, ID, 32'd1, 32'h00F, 1'b1, 1'b1, 1'b1);
    idle(10, 1'b1, 1'b0);
    read_all("after_reset");

    // 2: mismatched CI number is inert
    for (int k = 0; k < 10; k++)
      do_cycle("mismatch", 1'b1, 8'h02, 32'($urandom), 32'h00F, 1'($urandom), 1'($urandom), 1'b0);
    read_all("mismatch_rd");

    // 3: enable all, stall and busIdle held high
    do_cycle("enable_all", 1'b1, ID, 32'd0, 32'h00F, 1'b1, 1'b1, 1'b0);
    idle(5, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      do_cycle("count_rd", 1'b1, ID, 32'(i), 32'd0, 1'b1, 1'b1, 1'b0);

    // 4: disable all, counts freeze; then clear counter 0
    do_cycle("disable_all", 1'b1, ID, 32'd2, 32'h0F0, 1'($urandom), 1'($urandom), 1'b0);
    idle(8, 1'($urandom), 1'($urandom));
    read_all("frozen_rd");
    do_cycle("clear0", 1'b1, ID, 32'd0, 32'h100, 1'b0, 1'b0, 1'b0);
    do_cycle("clear0_rd", 1'b1, ID, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // 5: enable and disable together -> stays disabled
    do_cycle("en_dis", 1'b1, ID, 32'd0, 32'h011, 1'b1, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b0);
    read_all("en_dis_rd");

    // 6: preload counter 0 near the top and let it run past the boundary
    idle(1, 1'b0, 1'b0);
    force dut.g_cnt[0].u_cnt.count = 32'hFFFF_FFFE;
    #1;
    release dut.g_cnt[0].u_cnt.count;
    m_cnt[0] = 32'hFFFF_FFFE;
    do_cycle("preload_rd", 1'b1, ID, 32'd0, 32'h001, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0, 1'b0);
    do_cycle("wrap_rd", 1'b1, ID, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    do_cycle("wrap_rd2", 1'b1, ID, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // Mid-count reset, then nothing resumes until re-enabled
    do_cycle("enable_all2", 1'b1, ID, 32'd0, 32'h00F, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1, 1'b0);
    do_cycle("mid_reset", 1'b0, ID, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1, 1'b0);
    read_all("post_reset_rd");

    // Randomized traffic with sparse control bits and occasional reset
    for (int k = 0; k < 400; k++) begin
      logic        s;
      logic [7:0]  ci;
      logic [31:0] b;
      logic        r;
      s  = 1'($urandom);
      ci = ($urandom_range(0, 3) == 0) ? 8'h02 : ID;
      b  = $urandom & $urandom & $urandom;
      r  = ($urandom_range(0, 59) == 0);
      do_cycle("random", s, ci, $urandom, b, 1'($urandom), 1'($urandom), r);
    end
    read_all("final_rd");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
